// File: rtl/conv_tile_pkg.sv
// Shared tile geometry, derived sizes and loader state encoding for the
// convolution accelerator. Both the in_fm loader and the conv control path
// import this package so bank read and write mappings stay consistent.
package conv_tile_pkg;

   // Tile constants
   localparam int Tm = 16;   // input channels per tile
   localparam int Tr = 64;   // rows per channel tile
   localparam int Tc = 16;   // columns per channel tile
   localparam int X  = 4;    // in_fm banks = input-channel parallelism
   localparam int Y  = 4;    // output-channel parallelism
   localparam int K  = 3;    // kernel size
   localparam int S  = 1;    // stride

   // Derived sizes
   localparam int slice_size = Tr * Tc;
   localparam int bank_depth = (Tm / X) * slice_size;

   // Loader states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } load_state_e;

   // Counter width able to hold 0..n-1 (at least one bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_coord_counter.sv
// Nested column/row/channel coordinate counter for one tile. Advances only
// when en is high; c is the fastest index, ch the slowest. Wrap flags mark
// the last value of each level, and last marks the final coordinate.
module tile_coord_counter
   import conv_tile_pkg::*;
#(
   parameter int TM = 16,
   parameter int TR = 64,
   parameter int TC = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   output logic [cnt_width(TC)-1:0] c,
   output logic [cnt_width(TR)-1:0] r,
   output logic [cnt_width(TM)-1:0] ch,
   output logic                     c_wrap,
   output logic                     r_wrap,
   output logic                     ch_wrap,
   output logic                     last
);

   localparam int CW = cnt_width(TC);
   localparam int RW = cnt_width(TR);
   localparam int HW = cnt_width(TM);

   logic [CW-1:0] c_r;
   logic [RW-1:0] r_r;
   logic [HW-1:0] ch_r;

   assign c       = c_r;
   assign r       = r_r;
   assign ch      = ch_r;
   assign c_wrap  = (c_r  == CW'(TC - 1));
   assign r_wrap  = (r_r  == RW'(TR - 1));
   assign ch_wrap = (ch_r == HW'(TM - 1));
   assign last    = c_wrap & r_wrap & ch_wrap;

   // Advance the nested counters by one coordinate on each enabled cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_r  <= {CW{1'b0}};
         r_r  <= {RW{1'b0}};
         ch_r <= {HW{1'b0}};
      end else if (en) begin
         c_r <= c_wrap ? {CW{1'b0}} : c_r + CW'(1);
         if (c_wrap) begin
            r_r <= r_wrap ? {RW{1'b0}} : r_r + RW'(1);
         end else begin
            r_r <= r_r;
         end
         if (c_wrap && r_wrap) begin
            ch_r <= ch_wrap ? {HW{1'b0}} : ch_r + HW'(1);
         end else begin
            ch_r <= ch_r;
         end
      end else begin
         c_r  <= c_r;
         r_r  <= r_r;
         ch_r <= ch_r;
      end
   end

endmodule

// File: rtl/in_fm_tile_loader.sv
// Streams one input-feature-map tile into the X in_fm banks. Each accepted
// word goes to bank ch mod X at address (ch/X)*Tr*Tc + r*Tc + c, one cycle
// after acceptance; load_done pulses with the final write.
module in_fm_tile_loader
   import conv_tile_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 32,
   parameter int Tm = conv_tile_pkg::Tm,
   parameter int Tr = conv_tile_pkg::Tr,
   parameter int Tc = conv_tile_pkg::Tc,
   parameter int X  = conv_tile_pkg::X
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] in_fm_wr_data,
   output logic [AW-1:0] in_fm_wr_addr,
   output logic [X-1:0]  in_fm_wr_ena,
   output logic          load_busy,
   output logic          load_done
);

   localparam int CW         = cnt_width(Tc);
   localparam int RW         = cnt_width(Tr);
   localparam int HW         = cnt_width(Tm);
   localparam int BW         = cnt_width(X);
   localparam int tile_slice = Tr * Tc;

   // Elaboration-time geometry checks
   if ((Tm % X) != 0) begin : g_bad_tm
      $error("in_fm_tile_loader: Tm must be a multiple of X");
   end
   if (longint'(Tm / X) * longint'(tile_slice) > (longint'(1) << AW)) begin : g_bad_aw
      $error("in_fm_tile_loader: bank depth does not fit in AW address bits");
   end

   load_state_e   state_r, state_s;
   logic          load_start_r;
   logic          start_edge_s;
   logic          accept_s;
   logic          ready_r, busy_r, done_r;
   logic [DW-1:0] wr_data_r;
   logic [AW-1:0] wr_addr_r;
   logic [X-1:0]  wr_ena_r;
   logic [AW-1:0] base_r;
   logic [AW-1:0] addr_s;
   logic [BW-1:0] bank_s;
   logic [CW-1:0] c_s;
   logic [RW-1:0] r_s;
   logic [HW-1:0] ch_s;
   logic          c_wrap_s, r_wrap_s, ch_wrap_s, last_s;

   // ready_r mirrors (state_r == LOAD), so acceptance never waits on in_valid
   assign start_edge_s = load_start & ~load_start_r;
   assign accept_s     = in_valid & ready_r;
   assign bank_s       = BW'(32'(ch_s) % X);
   assign addr_s       = base_r + AW'(r_s) * AW'(Tc) + AW'(c_s);

   assign in_ready      = ready_r;
   assign in_fm_wr_data = wr_data_r;
   assign in_fm_wr_addr = wr_addr_r;
   assign in_fm_wr_ena  = wr_ena_r;
   assign load_busy     = busy_r;
   assign load_done     = done_r;

   tile_coord_counter #(
      .TM (Tm),
      .TR (Tr),
      .TC (Tc)
   ) u_coord (
      .clk     (clk),
      .rst     (rst),
      .en      (accept_s),
      .c       (c_s),
      .r       (r_s),
      .ch      (ch_s),
      .c_wrap  (c_wrap_s),
      .r_wrap  (r_wrap_s),
      .ch_wrap (ch_wrap_s),
      .last    (last_s)
   );

   // State register and start-edge history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         load_start_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         load_start_r <= load_start;
      end
   end

   // Next state: start edges only matter in IDLE; the last accepted beat ends LOAD
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_edge_s) state_s = LOAD;
            else              state_s = IDLE;
         end
         LOAD: begin
            if (accept_s && last_s) state_s = IDLE;
            else                    state_s = LOAD;
         end
         default: state_s = IDLE;
      endcase
   end

   // Channel-slice base address, stepped by one slice after every X channels
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_r <= {AW{1'b0}};
      end else if (accept_s && c_wrap_s && r_wrap_s) begin
         if (ch_wrap_s)                      base_r <= {AW{1'b0}};
         else if (bank_s == BW'(X - 1))      base_r <= base_r + AW'(tile_slice);
         else                                base_r <= base_r;
      end else begin
         base_r <= base_r;
      end
   end

   // Registered handshake, status and bank write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         wr_data_r <= {DW{1'b0}};
         wr_addr_r <= {AW{1'b0}};
         wr_ena_r  <= {X{1'b0}};
      end else begin
         ready_r <= (state_s == LOAD);
         busy_r  <= (state_s == LOAD) | (accept_s & last_s);
         done_r  <= accept_s & last_s;
         if (accept_s) begin
            wr_data_r <= in_data;
            wr_addr_r <= addr_s;
            wr_ena_r  <= X'(1) << bank_s;
         end else begin
            wr_data_r <= wr_data_r;
            wr_addr_r <= wr_addr_r;
            wr_ena_r  <= {X{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_in_fm_tile_loader.sv
// Self-checking bench for in_fm_tile_loader with an 8x4x4 tile over 4 banks.
// Writes are logged each cycle and compared with a coordinate-arithmetic model.
module tb_in_fm_tile_loader;

   localparam int TM = 8;
   localparam int TR = 4;
   localparam int TC = 4;
   localparam int XB = 4;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NW = TM * TR * TC;

   typedef struct {
      int              word;
      logic [XB-1:0]   ena;
      logic [AW-1:0]   addr;
      bit              done;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_fm_wr_data;
   logic [AW-1:0] in_fm_wr_addr;
   logic [XB-1:0] in_fm_wr_ena;
   logic          load_busy;
   logic          load_done;

   int checks = 0;
   int failures = 0;
   int step_no = 0;
   int done_cnt = 0;
   int done_step = -1;

   logic [AW-1:0] log_addr[$];
   logic [XB-1:0] log_ena[$];
   logic [DW-1:0] log_data[$];
   bit            log_done[$];
   int            log_step[$];
   int            acc_step[$];
   logic [DW-1:0] tile_data[NW];
   vec_t          vecs[7];

   in_fm_tile_loader #(
      .AW (AW), .DW (DW), .Tm (TM), .Tr (TR), .Tc (TC), .X (XB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start    (load_start),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_fm_wr_data (in_fm_wr_data),
      .in_fm_wr_addr (in_fm_wr_addr),
      .in_fm_wr_ena  (in_fm_wr_ena),
      .load_busy     (load_busy),
      .load_done     (load_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference mapping derived directly from the word's tile coordinates
   function automatic void model(input int n, output logic [XB-1:0] ena, output logic [AW-1:0] addr);
      int ch, r, c;
      ch   = n / (TR * TC);
      r    = (n / TC) % TR;
      c    = n % TC;
      ena  = '0;
      ena[ch % XB] = 1'b1;
      addr = AW'((ch / XB) * TR * TC + r * TC + c);
   endfunction

   task automatic clear_log();
      log_addr.delete(); log_ena.delete(); log_data.delete();
      log_done.delete(); log_step.delete(); acc_step.delete();
      done_cnt  = 0;
      done_step = -1;
   endtask

   // One clock: inputs captured at posedge, outputs sampled at the following negedge
   task automatic clk_step();
      @(posedge clk);
      @(negedge clk);
      step_no++;
      if (in_fm_wr_ena != '0) begin
         log_addr.push_back(in_fm_wr_addr);
         log_ena.push_back(in_fm_wr_ena);
         log_data.push_back(in_fm_wr_data);
         log_done.push_back(load_done);
         log_step.push_back(step_no);
      end
      if (load_done) begin
         done_cnt++;
         done_step = step_no;
      end
   endtask

   // mode 0: continuous valid, 1: toggling 1,0,1,0, 2: random valid
   task automatic run_load(input string tag, input int mode, input bit hold,
                           input int pulse_at, input int abort_at);
      int  idx, guard;
      bit  v, rdy;
      clear_log();
      load_start = 1'b1;
      in_valid   = 1'b0;
      clk_step();
      check({tag, " ready after start"}, in_ready, 1);
      check({tag, " busy after start"}, load_busy, 1);
      load_start = hold;
      idx   = 0;
      guard = 0;
      while (idx < NW && guard < 4000) begin
         if (abort_at >= 0 && idx == abort_at) break;
         guard++;
         if (mode == 0)      v = 1'b1;
         else if (mode == 1) v = (guard % 2) == 1;
         else                v = ($urandom_range(0, 9) < 7);
         load_start = hold | (pulse_at >= 0 && idx == pulse_at);
         in_valid   = v;
         in_data    = tile_data[idx];
         rdy        = in_ready;
         clk_step();
         if (v && rdy) begin
            acc_step.push_back(step_no);
            idx++;
         end
      end
      in_valid   = 1'b0;
      load_start = hold;
      if (abort_at < 0) check({tag, " stream completed"}, idx, NW);
   endtask

   task automatic verify_load(input string tag);
      logic [XB-1:0] e_ena;
      logic [AW-1:0] e_addr;
      check({tag, " write count"}, log_addr.size(), NW);
      for (int i = 0; i < log_addr.size() && i < NW; i++) begin
         model(i, e_ena, e_addr);
         check($sformatf("%s write %0d ena/addr/data", tag, i),
               {log_ena[i], log_addr[i], log_data[i]}, {e_ena, e_addr, tile_data[i]});
         check($sformatf("%s write %0d timing", tag, i), log_step[i], acc_step[i]);
      end
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " done with last write"}, done_step, acc_step[NW-1]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " in_ready"}, in_ready, 0);
      check({tag, " wr_ena"}, in_fm_wr_ena, 0);
      check({tag, " wr_addr"}, in_fm_wr_addr, 0);
      check({tag, " wr_data"}, in_fm_wr_data, 0);
      check({tag, " load_done"}, load_done, 0);
      check({tag, " load_busy"}, load_busy, 0);
   endtask

   initial begin
      logic [AW-1:0] prev_addr[$];
      int            mism, ready_seen;

      vecs[0] = '{word: 0,   ena: 4'b0001, addr: 8'd0,  done: 1'b0};
      vecs[1] = '{word: 5,   ena: 4'b0001, addr: 8'd5,  done: 1'b0};
      vecs[2] = '{word: 16,  ena: 4'b0010, addr: 8'd0,  done: 1'b0};
      vecs[3] = '{word: 17,  ena: 4'b0010, addr: 8'd1,  done: 1'b0};
      vecs[4] = '{word: 64,  ena: 4'b0001, addr: 8'd16, done: 1'b0};
      vecs[5] = '{word: 80,  ena: 4'b0010, addr: 8'd16, done: 1'b0};
      vecs[6] = '{word: 127, ena: 4'b1000, addr: 8'd31, done: 1'b1};
      for (int i = 0; i < NW; i++) tile_data[i] = DW'(i);

      // Reset state
      clk_step();
      clk_step();
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      clk_step();
      check_all_zero("idle after reset");

      // Continuous stream of words 0..127 plus spot-check table
      run_load("cont", 0, 1'b0, -1, -1);
      verify_load("cont");
      for (int i = 0; i < 7; i++) begin
         check($sformatf("table word %0d", vecs[i].word),
               {log_ena[vecs[i].word], log_addr[vecs[i].word], log_data[vecs[i].word], log_done[vecs[i].word]},
               {vecs[i].ena, vecs[i].addr, DW'(vecs[i].word), vecs[i].done});
      end
      check("cont ready in done cycle", in_ready, 0);
      check("cont busy in done cycle", load_busy, 1);
      clk_step();
      check("cont busy after done", load_busy, 0);
      check("cont done is one pulse", load_done, 0);

      // Toggling valid: last accept is 254 edges after the first, so done lands
      // in the 255th cycle after the first accepting edge
      run_load("toggle", 1, 1'b0, -1, -1);
      verify_load("toggle");
      check("toggle done latency", done_step - acc_step[0], 254);
      clk_step();

      // Random valid gaps with random data
      for (int i = 0; i < NW; i++) tile_data[i] = $urandom;
      run_load("random", 2, 1'b0, -1, -1);
      verify_load("random");
      for (int i = 0; i < NW; i++) tile_data[i] = DW'(i);
      clk_step();

      // Extra start pulse mid-load is ignored
      run_load("pulse50", 0, 1'b0, 50, -1);
      verify_load("pulse50");
      clk_step();

      // load_start held high for 300 cycles: one load only
      run_load("hold", 0, 1'b1, -1, -1);
      verify_load("hold");
      ready_seen = 0;
      in_valid   = 1'b1;
      for (int i = 0; i < 300 - NW - 1; i++) begin
         clk_step();
         if (in_ready) ready_seen++;
      end
      in_valid = 1'b0;
      check("hold no relaunch ready", ready_seen, 0);
      check("hold no extra writes", log_addr.size(), NW);
      check("hold single done", done_cnt, 1);
      load_start = 1'b0;
      clk_step();
      run_load("relaunch", 0, 1'b0, -1, -1);
      verify_load("relaunch");
      clk_step();

      // Reset at beat 60, then a fresh load
      run_load("abort", 0, 1'b0, -1, 60);
      check("abort no done", done_cnt, 0);
      check("abort writes before reset", log_addr.size(), 60);
      rst = 1'b0;
      #1;
      check_all_zero("async reset");
      in_valid = 1'b1;
      clk_step();
      check_all_zero("held reset");
      in_valid = 1'b0;
      rst = 1'b1;
      clk_step();
      run_load("after abort", 0, 1'b0, -1, -1);
      verify_load("after abort");
      check("after abort first write", {log_ena[0], log_addr[0]}, {4'b0001, 8'd0});
      clk_step();

      // Back-to-back loads: second start edge the cycle after load_done
      run_load("b2b first", 0, 1'b0, -1, -1);
      verify_load("b2b first");
      prev_addr = log_addr;
      run_load("b2b second", 0, 1'b0, -1, -1);
      verify_load("b2b second");
      mism = 0;
      for (int i = 0; i < NW; i++) begin
         if (i >= prev_addr.size() || i >= log_addr.size() || prev_addr[i] !== log_addr[i]) mism++;
      end
      check("b2b identical address sequence", mism, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
